vlg_design_gray: RTL and testbench

Registered binary-to-Gray-code converter with a valid flag. Each cycle that `i_en` is high, the binary word on `i_data` is converted to reflected Gray code. The result appears on `o_gray` one clock later, qualified by `o_vld`. It sits in the datapath as a drop-in encoder, for example ahead of clock-domain-crossing pointers or position encoders.

---
 rtl/vlg_gray_pkg.sv | 25 ++
 rtl/vlg_gray_stage.sv | 34 +++
 rtl/vlg_design_gray.sv | 58 +++++
 tb/tb_vlg_design_gray.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vlg_gray_pkg.sv
// Shared definitions for the binary-to-Gray encoder: default width, a word typedef
// and pure conversion helpers (bin2gray for reference, gray2bin for checkers).
package vlg_gray_pkg;

    localparam int unsigned GRAY_MSB_DEFAULT = 7;
    localparam int unsigned GRAY_MSB_MAX     = 31;

    // Widest legal word; narrower words are zero-extended into it.
    typedef logic [GRAY_MSB_MAX:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t r;
        r[GRAY_MSB_MAX] = g[GRAY_MSB_MAX];
        for (int i = GRAY_MSB_MAX - 1; i >= 0; i--) begin
            r[i] = r[i+1] ^ g[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/vlg_gray_stage.sv
// One register stage with a valid flag; the data word holds while the incoming valid is low.
module vlg_gray_stage
    import vlg_gray_pkg::*;
#(
    parameter int unsigned MSB = GRAY_MSB_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_vld,
    input  logic [MSB:0] i_data,
    output logic         o_vld,
    output logic [MSB:0] o_data
);

    logic         r_vld;
    logic [MSB:0] r_data;

    // rst_n is active-high in this codebase.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_data <= i_data;
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule

// File: rtl/vlg_design_gray.sv
// Registered binary-to-Gray encoder with valid flag.
// Define VLG_GRAY_PIPE2_EN to add a second register stage (2-cycle latency).
module vlg_design_gray
    import vlg_gray_pkg::*;
#(
    parameter int unsigned MSB = GRAY_MSB_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [MSB:0] i_data,
    output logic         o_vld,
    output logic [MSB:0] o_gray
);

    logic [MSB:0] w_gray;

    assign w_gray = i_data ^ (i_data >> 1);

`ifdef VLG_GRAY_PIPE2_EN
    logic         w_vld1;
    logic [MSB:0] w_gray1;

    vlg_gray_stage #(
        .MSB (MSB)
    ) u_stage1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (i_en),
        .i_data (w_gray),
        .o_vld  (w_vld1),
        .o_data (w_gray1)
    );

    vlg_gray_stage #(
        .MSB (MSB)
    ) u_stage2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (w_vld1),
        .i_data (w_gray1),
        .o_vld  (o_vld),
        .o_data (o_gray)
    );
`else
    vlg_gray_stage #(
        .MSB (MSB)
    ) u_stage1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (i_en),
        .i_data (w_gray),
        .o_vld  (o_vld),
        .o_data (o_gray)
    );
`endif

endmodule

// File: tb/tb_vlg_design_gray.sv
// Self-checking bench for vlg_design_gray: history-based reference model, directed and random steps.
module tb_vlg_design_gray;
    import vlg_gray_pkg::*;

`ifdef VLG_GRAY_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_en = 1'b0;
    logic [7:0]  i_data = '0;
    logic        o_vld;
    logic [7:0]  o_gray;
    logic        i_en0 = 1'b0;
    logic [0:0]  i_data0 = '0;
    logic        o_vld0;
    logic [0:0]  o_gray0;
    logic        i_en15 = 1'b0;
    logic [15:0] i_data15 = '0;
    logic        o_vld15;
    logic [15:0] o_gray15;

    int n_checks = 0;
    int n_fail   = 0;

    logic       h_en[$];
    logic [7:0] h_d[$];

    always #5 clk = ~clk;

    vlg_design_gray #(.MSB(7)) dut (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_data(i_data), .o_vld(o_vld), .o_gray(o_gray)
    );
    vlg_design_gray #(.MSB(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_en(i_en0), .i_data(i_data0), .o_vld(o_vld0),
        .o_gray(o_gray0)
    );
    vlg_design_gray #(.MSB(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .i_en(i_en15), .i_data(i_data15), .o_vld(o_vld15),
        .o_gray(o_gray15)
    );

    // Gray rule stated bit by bit: each bit is its binary bit XOR the bit above.
    function automatic logic [7:0] ref_gray(input logic [7:0] d);
        logic [7:0] g;
        for (int k = 0; k < 7; k++) g[k] = d[k] ^ d[k+1];
        g[7] = d[7];
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output word is the one sampled LAT-1 edges ago; data holds the latest enabled word
    // that has reached the output, or zero if none since reset.
    task automatic check_model();
        int         idx;
        logic       e_vld;
        logic [7:0] e_gray;
        idx    = h_en.size() - LAT;
        e_vld  = 1'b0;
        e_gray = '0;
        if (idx >= 0) begin
            e_vld = h_en[idx];
            for (int j = idx; j >= 0; j--) begin
                if (h_en[j]) begin
                    e_gray = ref_gray(h_d[j]);
                    break;
                end
            end
        end
        chk("model_vld", 32'(o_vld), 32'(e_vld));
        chk("model_gray", 32'(o_gray), 32'(e_gray));
    endtask

    task automatic tick(input logic en, input logic [7:0] d);
        i_en   = en;
        i_data = d;
        @(posedge clk);
        if (rst_n) begin
            h_en.delete();
            h_d.delete();
        end else begin
            h_en.push_back(en);
            h_d.push_back(d);
        end
        #1;
        check_model();
    endtask

    initial begin
        logic [7:0] prev;
        logic       have_prev;
        int         pulses;
        logic [7:0] bnd_in[4];
        logic [7:0] bnd_out[4];

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 100; i++) begin
            tick(1'($urandom), 8'($urandom));
            chk("reset_vld", 32'(o_vld), 32'd0);
            chk("reset_gray", 32'(o_gray), 32'd0);
        end
        rst_n = 1'b0;
        tick(1'b0, 8'h00);

        // Exhaustive sweep plus the 255 -> 0 wrap.
        have_prev = 1'b0;
        prev      = '0;
        pulses    = 0;
        for (int i = 0; i < 257 + LAT - 1; i++) begin
            if (i < 257) tick(1'b1, 8'(i));
            else         tick(1'b0, 8'h00);
            if (o_vld) begin
                pulses++;
                chk("sweep_inverse", gray2bin(32'(o_gray)), 32'((pulses - 1) & 8'hFF));
                if (have_prev) chk("sweep_one_bit", 32'($countones(prev ^ o_gray)), 32'd1);
                prev      = o_gray;
                have_prev = 1'b1;
            end
        end
        chk("sweep_pulses", 32'(pulses), 32'd257);

        // Boundary values.
        bnd_in  = '{8'h00, 8'hFF, 8'h7F, 8'h80};
        bnd_out = '{8'h00, 8'h80, 8'h40, 8'hC0};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, bnd_in[i]);
            for (int j = 1; j < LAT; j++) tick(1'b0, 8'h00);
            chk("boundary", 32'(o_gray), 32'(bnd_out[i]));
        end

        // Hold while disabled.
        tick(1'b1, 8'h55);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 8'hAA);
            chk("hold_gray", 32'(o_gray), 32'h7F);
            if (i >= LAT - 1) chk("hold_vld", 32'(o_vld), 32'd0);
        end

        // Mid-stream reset between edges, then resume.
        for (int i = 0; i < 20; i++) tick(1'b1, 8'(i + 100));
        #1 rst_n = 1'b1;
        #1;
        chk("midrst_vld", 32'(o_vld), 32'd0);
        chk("midrst_gray", 32'(o_gray), 32'd0);
        h_en.delete();
        h_d.delete();
        #1 rst_n = 1'b0;
        tick(1'b1, 8'h80);
        for (int j = 1; j < LAT; j++) tick(1'b0, 8'h00);
        chk("resume_gray", 32'(o_gray), 32'hC0);

        // Parameter corners on the narrow and wide instances.
        i_en0 = 1'b1; i_data0 = 1'b1;
        i_en15 = 1'b1; i_data15 = 16'hFFFF;
        for (int j = 0; j < LAT; j++) tick(1'b0, 8'h00);
        chk("msb0_gray", 32'(o_gray0), 32'd1);
        chk("msb0_vld", 32'(o_vld0), 32'd1);
        chk("msb15_ffff", 32'(o_gray15), 32'h8000);
        i_data15 = 16'h1234;
        for (int j = 0; j < LAT; j++) tick(1'b0, 8'h00);
        chk("msb15_1234", 32'(o_gray15), 32'h1B2E);
        i_en0 = 1'b0; i_en15 = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) tick(1'($urandom_range(0, 1)), 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
